// File: rtl/stack_arb_pkg.sv
// ---------------------------------------------------------------------------
// stack_arb_pkg
// Shared constants for the stack arbiter and its round-robin sub-arbiter.
//   OP_PUSH / OP_POP : encoding of a requester's req_op bit
//   ERR_DATA         : response data returned for a rejected operation
//   DATA_W_DEFAULT   : default operand width (matches the stack)
//   id_width()       : requester-ID width, never narrower than 1 bit
// ---------------------------------------------------------------------------
package stack_arb_pkg;

  localparam int DATA_W_DEFAULT = 32;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEAD;

  // $clog2(1) is 0, which would give zero-width ID ports; clamp to 1 bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stack_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts just after the index
// held in ptr and wraps modulo NREQ; the first requesting index wins.
// Ports:
//   req     in  NREQ  request vector
//   ptr     in  ID_W  index of the last winner (highest priority goes to ptr+1)
//   gnt     out NREQ  one-hot grant (all zero when nothing requests)
//   winner  out ID_W  index of the granted requester (0 when none)
//   any_gnt out 1     a grant was issued
// The pointer register lives in the caller so the block can be reused by any
// shared-resource controller that decides for itself when a grant is taken.
// ---------------------------------------------------------------------------
module rr_arbiter
  import stack_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] winner,
  output logic            any_gnt
);

  int              idx;
  logic [ID_W-1:0] idx_w;

  always_comb begin
    gnt     = '0;
    winner  = '0;
    any_gnt = 1'b0;
    idx     = 0;
    idx_w   = '0;
    // Offsets 1..NREQ visit every index exactly once, ending at ptr itself,
    // so the last winner has lowest priority.
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = ID_W'(idx);
      if (!any_gnt && req[idx_w]) begin
        any_gnt    = 1'b1;
        gnt[idx_w] = 1'b1;
        winner     = idx_w;
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// ---------------------------------------------------------------------------
// stack_arbiter
// Shares one LIFO stack between NREQ requesters. Each cycle at most one
// request is granted (round robin) and issued to the stack port; the response
// (pop data, zero for a push, or an error) appears one cycle later.
//
// Handshake: a requester holds req[i] (with req_op[i] and its req_data slice
// stable) until it sees gnt[i] high; the request is consumed at the clock
// edge that ends that cycle. resp_valid is a one-cycle pulse carrying the
// result of the operation granted in the previous cycle; there is no
// backpressure on the response.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req/req_op/req_data    per-requester request, op (1=push 0=pop), operand
//   gnt                    one-hot combinational grant
//   resp_valid/id/data/err registered response
//   stk_push/stk_pop/stk_data_in   command port to the stack
//   stk_data_out/stk_ready/stk_valid  stack top, not-full, not-empty
// ---------------------------------------------------------------------------
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ID_W   = id_width(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_op,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_err,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic [DATA_W-1:0]      stk_data_in,
  input  logic [DATA_W-1:0]      stk_data_out,
  input  logic                   stk_ready,
  input  logic                   stk_valid
);

  logic [ID_W-1:0]   rr_ptr;
  logic [NREQ-1:0]   arb_gnt;
  logic [ID_W-1:0]   winner;
  logic              arb_any;
  logic              granted;
  logic              win_op;
  logic [DATA_W-1:0] win_data;
  logic              issue_err;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .winner  (winner),
    .any_gnt (arb_any)
  );

  // Reset masks the grant so an operation seen during reset is never issued
  // and the requester simply keeps waiting.
  assign granted  = arb_any & ~rst;
  assign gnt      = rst ? '0 : arb_gnt;
  assign win_op   = req_op[winner];
  assign win_data = req_data[int'(winner)*DATA_W +: DATA_W];

  // Stack command: push and pop are mutually exclusive because they decode
  // the same single winner's op bit.
  always_comb begin
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    issue_err   = 1'b0;
    if (granted) begin
      if (win_op == OP_PUSH) begin
        if (stk_ready) begin
          stk_push    = 1'b1;
          stk_data_in = win_data;
        end else begin
          issue_err = 1'b1;
        end
      end else begin
        if (stk_valid) stk_pop   = 1'b1;
        else           issue_err = 1'b1;
      end
    end
  end

  // Round-robin pointer: moves to the winner, holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= ID_W'(NREQ - 1);
    end else if (granted) begin
      rr_ptr <= winner;
    end
  end

  // Response register. The pop value is captured from stk_data_out in the
  // grant cycle, i.e. before the stack drops its top at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= granted;
      if (granted) begin
        resp_id  <= winner;
        resp_err <= issue_err;
        if (issue_err)    resp_data <= DATA_W'(ERR_DATA);
        else if (stk_pop) resp_data <= stk_data_out;
        else              resp_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stack_arbiter
// Directed bench for stack_arbiter (NREQ=4, DATA_W=32) with a behavioural
// stack of programmable depth. Drivers queue the hand-computed grant order
// and responses; a negedge monitor pops and compares whenever the DUT grants
// or presents a response.
// ---------------------------------------------------------------------------
module tb_stack_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;
  localparam int RW     = ID_W + 1 + DATA_W;
  localparam logic [31:0] DEAD = 32'hDEAD_BEAD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req      = '0;
  logic [NREQ-1:0]        req_op   = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic [NREQ-1:0]        gnt;
  logic                   resp_valid;
  logic [ID_W-1:0]        resp_id;
  logic [DATA_W-1:0]      resp_data;
  logic                   resp_err;
  logic                   stk_push;
  logic                   stk_pop;
  logic [DATA_W-1:0]      stk_data_in;
  logic [DATA_W-1:0]      stk_data_out;
  logic                   stk_ready;
  logic                   stk_valid;

  stack_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_op       (req_op),
    .req_data     (req_data),
    .gnt          (gnt),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_ready    (stk_ready),
    .stk_valid    (stk_valid)
  );

  // ---------------- behavioural stack ----------------
  logic [DATA_W-1:0] stk_mem [8];
  int stk_count = 0;
  int stk_depth = 8;

  assign stk_ready    = (stk_count < stk_depth);
  assign stk_valid    = (stk_count > 0);
  assign stk_data_out = (stk_count > 0) ? stk_mem[stk_count-1] : '0;

  always @(posedge clk) begin
    if (stk_push && stk_count < 8) begin
      stk_mem[stk_count] <= stk_data_in;
      stk_count <= stk_count + 1;
    end else if (stk_pop && stk_count > 0) begin
      stk_count <= stk_count - 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int            exp_gnt_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [NREQ-1:0] last_gnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: all DUT outputs sampled at negedge, away from the active edge.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    int            w;
    logic          e_push, e_pop;
    logic [DATA_W-1:0] e_din;
    last_gnt = gnt;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL resp_unexpected: got id=%0d err=%0b data=%0h expected none",
                 resp_id, resp_err, resp_data);
      end else begin
        e = exp_q.pop_front();
        check("resp", {resp_id, resp_err, resp_data}, e);
      end
    end
    if (gnt != '0) begin
      if (exp_gnt_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL gnt_unexpected: got %b expected 0000", gnt);
      end else begin
        w = exp_gnt_q.pop_front();
        check("gnt", gnt, 64'(1) << w);
        e_push = req_op[w] && (stk_count < stk_depth);
        e_pop  = !req_op[w] && (stk_count > 0);
        e_din  = e_push ? req_data[w*DATA_W +: DATA_W] : '0;
        check("strobes", {stk_push, stk_pop, stk_data_in}, {e_push, e_pop, e_din});
      end
    end else begin
      check("idle_strobes", {stk_push, stk_pop, stk_data_in}, '0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Holds requests until each is granted; consumed bits drop after the edge.
  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      req = req & ~last_gnt;
      if (req == '0) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL drain_timeout: got req=%b expected 0000", req);
    req = '0;
  endtask

  task automatic set_op(input int id, input logic op, input logic [DATA_W-1:0] d);
    req_op[id] = op;
    req_data[id*DATA_W +: DATA_W] = d;
  endtask

  task automatic single(input int id, input logic op, input logic [DATA_W-1:0] d,
                        input logic [DATA_W-1:0] exp_data, input logic exp_err);
    sync();
    set_op(id, op, d);
    exp_gnt_q.push_back(id);
    exp_q.push_back({ID_W'(id), exp_err, exp_data});
    req = NREQ'(1) << id;
    drain(8);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id",    resp_id,    0);
    check("rst_resp_data",  resp_data,  0);
    check("rst_resp_err",   resp_err,   0);
    check("rst_gnt",        gnt,        0);
    rst = 1'b0;

    // Push 0x11 then pop it back from requester 0
    single(0, 1'b1, 32'h11, 32'h0,  1'b0);
    single(0, 1'b0, 32'h0,  32'h11, 1'b0);
    check("empty_after_pop", stk_count, 0);

    // Pre-fill A,B,C,D via requester 3 (leaves the pointer at 3)
    single(3, 1'b1, 32'hA000_000A, 32'h0, 1'b0);
    single(3, 1'b1, 32'hB000_000B, 32'h0, 1'b0);
    single(3, 1'b1, 32'hC000_000C, 32'h0, 1'b0);
    single(3, 1'b1, 32'hD000_000D, 32'h0, 1'b0);
    check("prefill_count", stk_count, 4);

    // All four pop at once: grants 0,1,2,3 and data D,C,B,A
    sync();
    req_op = '0;
    for (int i = 0; i < NREQ; i++) exp_gnt_q.push_back(i);
    exp_q.push_back({2'd0, 1'b0, 32'hD000_000D});
    exp_q.push_back({2'd1, 1'b0, 32'hC000_000C});
    exp_q.push_back({2'd2, 1'b0, 32'hB000_000B});
    exp_q.push_back({2'd3, 1'b0, 32'hA000_000A});
    req = 4'b1111;
    drain(10);
    check("empty_after_burst", stk_count, 0);

    // Pop on empty from requester 2
    single(2, 1'b0, 32'h0, DEAD, 1'b1);

    // Full stack of depth 2 rejects a push from requester 1
    stk_depth = 2;
    single(1, 1'b1, 32'h21, 32'h0, 1'b0);
    single(1, 1'b1, 32'h22, 32'h0, 1'b0);
    single(1, 1'b1, 32'h55, DEAD,  1'b1);
    check("full_count", stk_count, 2);
    check("full_top",   stk_data_out, 32'h22);
    single(1, 1'b0, 32'h0, 32'h22, 1'b0);
    single(1, 1'b0, 32'h0, 32'h21, 1'b0);
    stk_depth = 8;

    // Fairness: move the pointer to 3, then 0 and 3 hold req for 6 cycles
    single(3, 1'b0, 32'h0, DEAD, 1'b1);
    sync();
    req_op = '0;
    for (int k = 0; k < 3; k++) begin
      exp_gnt_q.push_back(0);
      exp_q.push_back({2'd0, 1'b1, DEAD});
      exp_gnt_q.push_back(3);
      exp_q.push_back({2'd3, 1'b1, DEAD});
    end
    req = 4'b1001;
    repeat (6) @(posedge clk);
    #1;
    req = '0;

    // Reset with requests pending: nothing granted, pointer back to NREQ-1
    single(0, 1'b0, 32'h0, DEAD, 1'b1);
    rst    = 1'b1;
    req_op = '0;
    req    = 4'b0110;
    @(negedge clk);
    check("rst_hold_gnt",   gnt,      0);
    check("rst_hold_pop",   stk_pop,  0);
    sync();
    check("rst_resp_valid2", resp_valid, 0);
    sync();
    check("rst_resp_valid3", resp_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_gnt_q.push_back(i);
      exp_q.push_back({ID_W'(i), 1'b1, DEAD});
    end
    req = 4'b0111;
    drain(10);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_empty",   exp_q.size(),     0);
    check("exp_gnt_empty", exp_gnt_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one 32-bit LIFO stack between NREQ independent requesters; each requester issues single push or pop operations through a req/gnt handshake.
- Performs round-robin arbitration and drives the stack's push/pop/data_in port, at most one operation per cycle.
- Returns a registered response (pop data or error status) tagged with the requester ID.
- Sits between client blocks and the stack instance; it is the only master of the stack port.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DATA_W, 32, operand width; must equal the stack data width.
- ID_W, $clog2(NREQ), derived requester-ID width; not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held high until the matching gnt bit.
- req_op  in  NREQ  per-requester operation: 1 = push, 0 = pop.
- req_data  in  NREQ*DATA_W  per-requester push operand; slice i is requester i.
- gnt  out  NREQ  one-hot grant, combinational, at most one bit set; the request is consumed in that cycle.
- resp_valid  out  1  one-cycle pulse: response for the operation granted in the previous cycle.
- resp_id  out  ID_W  requester index of the response.
- resp_data  out  DATA_W  popped value; 0 for a push; 32'hDEAD_BEAD for an error.
- resp_err  out  1  1 = the operation was rejected (push while full, or pop while empty).
- stk_push  out  1  push strobe to the stack.
- stk_pop  out  1  pop strobe to the stack.
- stk_data_in  out  DATA_W  push data to the stack; 0 when stk_push = 0.
- stk_data_out  in  DATA_W  current top-of-stack value from the stack.
- stk_ready  in  1  stack not full.
- stk_valid  in  1  stack not empty.

Behaviour:
- Reset (rst high at a clk edge):
  - rr_ptr <= NREQ-1, so requester 0 has first priority.
  - resp_valid, resp_id, resp_data and resp_err <= 0.
  - While rst is high, gnt, stk_push and stk_pop are forced to 0.
  - The stack itself is not reset by this block.
- Arbitration:
  - The search order is rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - The first index with req set wins; gnt[winner] = 1 in the same cycle.
  - On a grant, rr_ptr <= winner at the clock edge; with no request, rr_ptr holds.
  - Eligibility does not depend on stack state, so a requester never starves.
- Issue (combinational, in the grant cycle):
  - Push with stk_ready = 1: stk_push = 1 and stk_data_in = that requester's req_data slice.
  - Pop with stk_valid = 1: stk_pop = 1, and stk_data_out is sampled into the response register.
  - Push with stk_ready = 0, or pop with stk_valid = 0: no stack strobe; the response is an error.
  - stk_push and stk_pop are never high together.
- Response:
  - Latency is exactly 1 cycle from the grant edge.
  - resp_valid = 1 for one cycle, with resp_id = winner.
  - resp_data and resp_err are set as listed under Ports.
  - Response fields hold their last values while resp_valid = 0.
- Throughput: one operation per cycle under back-to-back requests; the response pipe never stalls (no backpressure).
- Simultaneous requests: one grant per cycle; losers keep req high and wait.
- Reset mid-operation: a response pending at the reset edge is dropped (resp_valid = 0); an operation granted in the reset cycle is not issued.
- NREQ = 1: the arbiter reduces to a pass-through; the pointer stays at 0.

Decomposition:
- Shared package stack_arb_pkg:
  - OP_PUSH = 1'b1 and OP_POP = 1'b0.
  - ERR_DATA = 32'hDEAD_BEAD.
  - DATA_W default 32.
- Sub-module rr_arbiter (NREQ): inputs req and ptr; outputs one-hot gnt, winner index and any_gnt. It is reusable by other shared-resource controllers.

Test Plan:
- Reset, then requester 0 pushes 32'h11, then pops → push response: resp_valid, id 0, data 0, err 0; pop response: data 32'h11, err 0; the stack returns to empty.
- All 4 requesters pop simultaneously with req held, stack pre-filled with A, B, C, D (D on top) → grants in order 0, 1, 2, 3 on consecutive cycles; responses D, C, B, A with ids 0, 1, 2, 3.
- Pop on an empty stack from requester 2 → no stk_pop; response id 2, err 1, data 32'hDEAD_BEAD.
- Stack SIZE = 2 filled, then requester 1 pushes 32'h55 → no stk_push; err 1, data 32'hDEAD_BEAD; the stack contents are unchanged.
- Fairness: requesters 0 and 3 hold req continuously → grants alternate 0, 3, 0, 3; no requester waits more than NREQ-1 cycles.
- Assert rst in the cycle after a grant → resp_valid stays 0; the next grant after reset goes to requester 0 first.
